muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencing controller for the shared multi-cycle multiplier and divider in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and drives the start/operand handshake of the iterative units. It stalls the pipeline while a unit is busy, commits 64-bit results into the architectural HI/LO registers, and handles flush aborts and divide-by-zero.

Parameters:
TIMEOUT, 40, max cycles from start to unit ready before err_o is raised.
DIVZ_LO, 32'hFFFFFFFF, LO value written on divide by zero.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_i  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
op_valid_i  in  1  op_i/a_i/b_i valid this cycle
a_i  in  32  rs operand (dividend/multiplicand; mthi/mtlo source)
b_i  in  32  rt operand
flush_i  in  1  pipeline flush; aborts the in-flight op
stall_o  out  1  hold EX and earlier stages
hi_o  out  32  architectural HI
lo_o  out  32  architectural LO
mul_start_o  out  1  multiplier start
mul_signed_o  out  1  signed multiply
mul_a_o, mul_b_o  out  32 each  multiplier operands
mul_result_i  in  64  {hi,lo} product
mul_ready_i  in  1  multiplier result valid
div_start_o, div_signed_o, div_a_o, div_b_o  out  1/1/32/32  divider equivalents
div_result_i  in  64  {remainder,quotient}
div_ready_i  in  1  divider result valid
err_o  out  1  sticky; unit timed out

Behaviour:
- Reset: state IDLE; hi_o, lo_o, all *_start_o, *_signed_o, operand outputs, stall_o and err_o = 0; timeout counter = 0.
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE, DRAIN.
- IDLE with op_valid_i and no flush_i:
  - mthi/mtlo: write hi_o/lo_o at the clock edge; no stall; stay IDLE.
  - mult/multu: latch operands to mul_a_o/mul_b_o; mul_signed_o = (op==1); mul_start_o=1; go MUL_BUSY.
  - div/divu with b_i!=0: same on the div port; go DIV_BUSY.
  - div/divu with b_i==0: no unit start; hi_o<=a_i, lo_o<=DIVZ_LO; go DONE.
- stall_o is combinational. It is 1 in IDLE when a valid mult/multu/div/divu op is presented, and 1 in MUL_BUSY, DIV_BUSY and DRAIN. It is 0 in DONE, which releases the instruction exactly one cycle after commit.
- BUSY states:
  - start and operands are held constant until the matching ready is sampled high.
  - On ready: HI<=result[63:32], LO<=result[31:0]; drop start the same edge; go DONE.
  - A ready input is ignored unless its unit is in a BUSY or DRAIN state.
  - Timeout counter increments each BUSY cycle. When it reaches TIMEOUT: err_o<=1, start dropped, go DONE with HI/LO unchanged.
- DONE: one cycle; counter cleared; next state IDLE. An op presented in DONE is not accepted; EX re-presents it in IDLE.
- Flush:
  - In IDLE, flush_i suppresses acceptance, including mthi/mtlo.
  - In MUL_BUSY/DIV_BUSY, flush_i drops start and goes to DRAIN; HI/LO are never written by the aborted op.
  - DRAIN waits for the active unit's ready (or TIMEOUT), discards the result, then goes IDLE. stall_o=1 throughout DRAIN.
  - flush_i in DONE has no effect, because the commit has already happened.
- Simultaneous ready and flush_i in a BUSY state: the flush wins, the result is discarded, and the state goes IDLE directly.
- Latency: mult = 1 (issue) + unit latency + 1 (DONE); divide by zero = 2 cycles.
- Only one unit is ever active, so start_o is never high on both ports.
- Reset mid-operation returns to IDLE with all outputs cleared; the unit is reset by the same rst.

Test Plan:
- mthi a_i=0x12345678, then mtlo a_i=0x9ABCDEF0, no stall -> hi_o=0x12345678, lo_o=0x9ABCDEF0 next cycle.
- mult a=0xFFFFFFFE (-2), b=3; unit returns ready with 0xFFFFFFFF_FFFFFFFA -> mul_signed_o=1, start held until ready, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, stall_o drops in DONE.
- divu a=100, b=7; divider returns {2,14} -> hi_o=2, lo_o=14; div_start_o never high while mul_start_o is high.
- div a=0x55, b=0 -> no div_start_o, hi_o=0x55, lo_o=0xFFFFFFFF, stall_o high exactly 1 cycle.
- multu in flight, flush_i pulsed mid-op, then ready arrives -> DRAIN, HI/LO unchanged, return to IDLE; flush coincident with ready also leaves HI/LO unchanged.
- Unit ready tied low -> err_o=1 after TIMEOUT=40 busy cycles, return to IDLE; rst asserted mid-MUL_BUSY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the shared iterative multiplier/divider.
// Issues start/operands, stalls the pipe while busy, commits {HI,LO}, handles flush and timeout.
module muldiv_ctrl #(
    parameter int unsigned TIMEOUT = 40,
    parameter logic [31:0] DIVZ_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op_i,
    input  logic        op_valid_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        mul_start_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [63:0] mul_result_i,
    input  logic        mul_ready_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_BUSY,
        S_DIV_BUSY,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t        r_state;
    logic          r_unit_div;
    logic [CW-1:0] r_cnt;

    logic          w_is_mul;
    logic          w_is_div;
    logic          w_accept;
    logic          w_ready;
    logic          w_timeout;
    logic [63:0]   w_result;

    assign w_is_mul  = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign w_is_div  = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    assign w_accept  = (r_state == S_IDLE) && op_valid_i && !flush_i;
    // Only the unit that was started may complete; r_unit_div is meaningful in BUSY/DRAIN only.
    assign w_ready   = r_unit_div ? div_ready_i : mul_ready_i;
    assign w_result  = r_unit_div ? div_result_i : mul_result_i;
    // >= so a flush landing on the last busy cycle still times out in DRAIN.
    assign w_timeout = (r_cnt >= CW'(TIMEOUT - 1));

    // NOTE: stall_o must be combinational so the issuing instruction is held in the same cycle.
    always_comb begin
        stall_o = 1'b0;
        case (r_state)
            S_IDLE:                           stall_o = op_valid_i && (w_is_mul || w_is_div);
            S_MUL_BUSY, S_DIV_BUSY, S_DRAIN:  stall_o = 1'b1;
            default:                          stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_unit_div   <= 1'b0;
            r_cnt        <= '0;
            hi_o         <= '0;
            lo_o         <= '0;
            mul_start_o  <= 1'b0;
            mul_signed_o <= 1'b0;
            mul_a_o      <= '0;
            mul_b_o      <= '0;
            div_start_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_a_o      <= '0;
            div_b_o      <= '0;
            err_o        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        if (op_i == OP_MTHI) begin
                            hi_o <= a_i;
                        end else if (op_i == OP_MTLO) begin
                            lo_o <= a_i;
                        end else if (w_is_mul) begin
                            mul_a_o      <= a_i;
                            mul_b_o      <= b_i;
                            mul_signed_o <= (op_i == OP_MULT);
                            mul_start_o  <= 1'b1;
                            r_unit_div   <= 1'b0;
                            r_state      <= S_MUL_BUSY;
                        end else if (w_is_div && (b_i != 32'd0)) begin
                            div_a_o      <= a_i;
                            div_b_o      <= b_i;
                            div_signed_o <= (op_i == OP_DIV);
                            div_start_o  <= 1'b1;
                            r_unit_div   <= 1'b1;
                            r_state      <= S_DIV_BUSY;
                        end else if (w_is_div) begin
                            hi_o    <= a_i;
                            lo_o    <= DIVZ_LO;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MUL_BUSY, S_DIV_BUSY: begin
                    if (flush_i) begin
                        mul_start_o <= 1'b0;
                        div_start_o <= 1'b0;
                        if (w_ready) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1);
                            r_state <= S_DRAIN;
                        end
                    end else if (w_ready) begin
                        hi_o        <= w_result[63:32];
                        lo_o        <= w_result[31:0];
                        mul_start_o <= 1'b0;
                        div_start_o <= 1'b0;
                        r_state     <= S_DONE;
                    end else if (w_timeout) begin
                        err_o       <= 1'b1;
                        mul_start_o <= 1'b0;
                        div_start_o <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_ready || w_timeout) begin
                        if (!w_ready) err_o <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl; the bench plays both iterative units
// and predicts HI/LO/err/stall from the instruction semantics.
module tb_muldiv_ctrl;

    localparam int          TIMEOUT = 40;
    localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op_i;
    logic        op_valid_i;
    logic [31:0] a_i, b_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] hi_o, lo_o;
    logic        mul_start_o, mul_signed_o;
    logic [31:0] mul_a_o, mul_b_o;
    logic [63:0] mul_result_i;
    logic        mul_ready_i;
    logic        div_start_o, div_signed_o;
    logic [31:0] div_a_o, div_b_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        err_o;

    muldiv_ctrl #(.TIMEOUT(TIMEOUT), .DIVZ_LO(DIVZ_LO)) dut (
        .clk(clk), .rst(rst), .op_i(op_i), .op_valid_i(op_valid_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o),
        .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o), .mul_a_o(mul_a_o),
        .mul_b_o(mul_b_o), .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o), .div_a_o(div_a_o),
        .div_b_o(div_b_o), .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sp;
        logic [63:0] ua, ub;
        int          q, r;
        ref_result = '0;
        case (op)
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); ref_result = sp; end
            3'd2: begin ua = {32'd0, a}; ub = {32'd0, b}; ref_result = ua * ub; end
            3'd3: begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); ref_result = {r, q}; end
            3'd4: ref_result = {a % b, a / b};
            default: ref_result = '0;
        endcase
    endfunction

    task automatic check_arch(input string tag);
        check({tag, "_hi"}, hi_o, m_hi);
        check({tag, "_lo"}, lo_o, m_lo);
        check({tag, "_err"}, err_o, m_err);
    endtask

    // One instruction from IDLE back to IDLE. lat = cycles until the unit answers (0 = never),
    // flush_at = busy cycle carrying flush (0 = none), idle_flush = flush in the issue cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int flush_at, input bit idle_flush);
        bit          is_mul, is_div, draining, done_state;
        logic [63:0] res;
        is_mul = (op == 3'd1) || (op == 3'd2);
        is_div = (op == 3'd3) || (op == 3'd4);
        op_valid_i = 1'b1; op_i = op; a_i = a; b_i = b; flush_i = idle_flush;
        // Stray ready pulses while idle must be ignored.
        mul_ready_i = 1'($urandom_range(0, 1)); mul_result_i = {$urandom, $urandom};
        div_ready_i = 1'($urandom_range(0, 1)); div_result_i = {$urandom, $urandom};
        #1;
        check("stall_issue", stall_o, is_mul || is_div);
        tick();
        op_valid_i = 1'b0; op_i = '0; flush_i = 1'b0; mul_ready_i = 1'b0; div_ready_i = 1'b0;
        if (idle_flush || !(is_mul || is_div)) begin
            if (!idle_flush && op == 3'd5) m_hi = a;
            if (!idle_flush && op == 3'd6) m_lo = a;
            #1;
            check("idle_stall", stall_o, 1'b0);
            check("idle_starts", {mul_start_o, div_start_o}, 2'b00);
            check_arch("idle");
            return;
        end
        if (is_div && b == 32'd0) begin
            m_hi = a; m_lo = DIVZ_LO;
            #1;
            check("divz_stall", stall_o, 1'b0);
            check("divz_start", div_start_o, 1'b0);
            check_arch("divz");
            tick();
            return;
        end
        res = ref_result(op, a, b);
        draining = 1'b0;
        done_state = 1'b0;
        for (int k = 1; k <= TIMEOUT + 2; k++) begin
            #1;
            check("busy_stall", stall_o, 1'b1);
            if (!draining) begin
                check("start_pair", {mul_start_o, div_start_o}, {is_mul, is_div});
                check("operands", is_mul ? {mul_a_o, mul_b_o} : {div_a_o, div_b_o}, {a, b});
                check("signed", is_mul ? mul_signed_o : div_signed_o, (op == 3'd1) || (op == 3'd3));
            end else begin
                check("drain_starts", {mul_start_o, div_start_o}, 2'b00);
            end
            // The idle unit chatters with garbage; only the started unit may be heard.
            if (is_mul) begin
                mul_ready_i = (k == lat); mul_result_i = res;
                div_ready_i = 1'($urandom_range(0, 1)); div_result_i = {$urandom, $urandom};
            end else begin
                div_ready_i = (k == lat); div_result_i = res;
                mul_ready_i = 1'($urandom_range(0, 1)); mul_result_i = {$urandom, $urandom};
            end
            flush_i = (k == flush_at);
            tick();
            mul_ready_i = 1'b0; div_ready_i = 1'b0; flush_i = 1'b0;
            if (k == flush_at && !draining) begin
                if (k == lat) break;
                draining = 1'b1;
            end else if (k == lat) begin
                if (!draining) begin
                    m_hi = res[63:32]; m_lo = res[31:0]; done_state = 1'b1;
                end
                break;
            end else if (lat == 0 && k == TIMEOUT) begin
                m_err = 1'b1; done_state = 1'b1;
                break;
            end
        end
        #1;
        check("end_stall", stall_o, 1'b0);
        check("end_starts", {mul_start_o, div_start_o}, 2'b00);
        check_arch("end");
        if (done_state) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall_o, 1'b0);
        check({tag, "_hilo"}, {hi_o, lo_o}, 64'd0);
        check({tag, "_ctl"}, {mul_start_o, mul_signed_o, div_start_o, div_signed_o, err_o}, 5'd0);
        check({tag, "_mops"}, {mul_a_o, mul_b_o}, 64'd0);
        check({tag, "_dops"}, {div_a_o, div_b_o}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          lat, fl;
        rst = 1'b1; op_i = '0; op_valid_i = 1'b0; a_i = '0; b_i = '0; flush_i = 1'b0;
        mul_result_i = '0; mul_ready_i = 1'b0; div_result_i = '0; div_ready_i = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        run_op(3'd5, 32'h1234_5678, 32'h0, 0, 0, 1'b0);
        run_op(3'd6, 32'h9ABC_DEF0, 32'h0, 0, 0, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 4, 0, 1'b0);
        check("mult_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_lo", lo_o, 32'hFFFF_FFFA);
        run_op(3'd4, 32'd100, 32'd7, 5, 0, 1'b0);
        check("divu_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
        run_op(3'd3, 32'h55, 32'd0, 0, 0, 1'b0);
        check("divz_hilo", {hi_o, lo_o}, {32'h55, 32'hFFFF_FFFF});
        run_op(3'd2, 32'hDEAD_BEEF, 32'h1234, 6, 2, 1'b0);
        run_op(3'd2, 32'hCAFE_F00D, 32'h77, 3, 3, 1'b0);
        run_op(3'd6, 32'hAAAA_5555, 32'h0, 0, 0, 1'b1);
        run_op(3'd1, 32'd1, 32'd1, 1, 0, 1'b0);
        run_op(3'd2, 32'd9, 32'd9, 0, 0, 1'b0);
        check("timeout_err", err_o, 1'b1);

        for (int i = 0; i < 80; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (op == 3'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            if ((op == 3'd1 || op == 3'd2) && b == 32'd0) b = 32'd5;
            lat = $urandom_range(1, 6);
            fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
            run_op(op, a, b, lat, fl, $urandom_range(0, 7) == 0);
        end

        // Reset while the multiplier is busy.
        op_valid_i = 1'b1; op_i = 3'd1; a_i = 32'h1111; b_i = 32'h2222;
        tick();
        op_valid_i = 1'b0; op_i = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
